// File: rtl/pwm_capture_pkg.sv
// Shared types for pwm_capture: FSM state, FIFO result entry and glitch-filter length.
package pwm_capture_pkg;

    localparam int unsigned GLITCH_LEN = 3;
    // Widest counter a result entry can carry; instances use CNT_W <= RES_CNT_W.
    localparam int unsigned RES_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [RES_CNT_W-1:0] high;
        logic [RES_CNT_W-1:0] period;
        logic                 sat;
    } result_t;

endpackage

// File: rtl/pwm_capture_fifo.sv
// Show-ahead FIFO: rdata_o is the head entry whenever empty_o is low; sticky overrun on dropped pushes.
module pwm_capture_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [7:0]
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   full_o,
    output logic   overrun_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic [OCC_W-1:0] count_d;
    logic             empty_q;
    logic             full_q;
    logic             overrun_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | pop_i);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == OCC_W'(DEPTH));
            overrun_q <= overrun_q | (push_i & full_q & ~pop_i);
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (clk cycles) of gpio_in_i[pin_sel_i] into a result FIFO.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to ignore pulses shorter than GLITCH_LEN cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [4:0]       pin_sel_i,
    input  logic [31:0]      gpio_in_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] dout_high_o,
    output logic [CNT_W-1:0] dout_period_o,
    output logic             rx_empty_o,
    output logic             rx_full_o,
    output logic             overrun_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_s;
    logic                   s;
    logic                   s_d_q;
    logic                   rise;
    logic                   fall;
    cap_state_e             state_q;
    logic [CNT_W-1:0]       hcnt_q;
    logic [CNT_W-1:0]       pcnt_q;
    logic [CNT_W-1:0]       hcnt_inc;
    logic [CNT_W-1:0]       pcnt_inc;
    logic                   push;
    result_t                wr_entry;
    result_t                head;
    logic                   unused_head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_i[pin_sel_i]};
        end
    end

    assign raw_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned GCNT_W = $clog2(GLITCH_LEN);

    logic              filt_q;
    logic [GCNT_W-1:0] gcnt_q;

    // Output follows raw_s only after GLITCH_LEN consecutive samples at the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else if (raw_s == filt_q) begin
            gcnt_q <= '0;
        end else if (gcnt_q == GCNT_W'(GLITCH_LEN - 1)) begin
            filt_q <= raw_s;
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_q + GCNT_W'(1);
        end
    end

    assign s = filt_q;
`else
    assign s = raw_s;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    assign hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_W'(1);
    assign pcnt_inc = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_W'(1);

    // Measurement FSM; a rise in LOW closes the current period and immediately opens the next.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
        end else if (!en_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                        hcnt_q  <= CNT_W'(1);
                        pcnt_q  <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    pcnt_q <= pcnt_inc;
                    if (fall) begin
                        state_q <= LOW;
                    end else begin
                        hcnt_q <= hcnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_q <= HIGH;
                        hcnt_q  <= CNT_W'(1);
                        pcnt_q  <= CNT_W'(1);
                    end else begin
                        pcnt_q <= pcnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign push = en_i && (state_q == LOW) && rise;

    // Counters only grow within a period, so a saturated period shows up as a counter at max.
    always_comb begin
        wr_entry        = '0;
        wr_entry.high   = RES_CNT_W'(hcnt_q);
        wr_entry.period = RES_CNT_W'(pcnt_q);
        wr_entry.sat    = (hcnt_q == CNT_MAX) || (pcnt_q == CNT_MAX);
    end

    pwm_capture_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (result_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .wdata_i   (wr_entry),
        .pop_i     (pop_i),
        .rdata_o   (head),
        .empty_o   (rx_empty_o),
        .full_o    (rx_full_o),
        .overrun_o (overrun_o)
    );

    assign dout_high_o   = head.high[CNT_W-1:0];
    assign dout_period_o = head.period[CNT_W-1:0];
    assign sat_o         = head.sat;
    assign unused_head   = ^{head.high, head.period};

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiver/measurement counterpart to the PIO PWM program: samples one selected `gpio_out`-style pin and measures high time and period in `clk` cycles.
- Results go into a small result FIFO that a host pops, mirroring the PIO's `rx_empty`/pop style.
- Sits beside `pio` in sim and on FPGA to close the loop on PWM generation (self-check of duty/period).

Parameters:
- CNT_W, 24, width of the high-time and period counters.
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2).
- SYNC_STAGES, 2, input synchronizer flops (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: asserted when 0, released synchronously to `clk`.
- en  in  1  capture enable; 0 forces IDLE.
- pin_sel  in  5  index of the `gpio_in` bit to measure.
- gpio_in  in  32  pin bus (asynchronous to clk).
- pop  in  1  remove the head FIFO entry; ignored when empty.
- dout_high  out  CNT_W  head entry high time (cycles).
- dout_period  out  CNT_W  head entry period (cycles).
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- overrun  out  1  sticky; a measurement was dropped because the FIFO was full.
- sat  out  1  head entry had a counter saturate.

Behaviour:
- Reset values:
  - `dout_high`, `dout_period` = 0.
  - `rx_empty` = 1; `rx_full`, `overrun`, `sat` = 0.
  - FSM = IDLE; counters and synchronizer = 0.
- Input path:
  - `s` = `gpio_in[pin_sel]` through SYNC_STAGES flops; `s_d` = `s` delayed one cycle.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
  - Latency from pin edge to detection is SYNC_STAGES+1 cycles.
- FSM states IDLE, HIGH, LOW:
  - IDLE: wait for `rise` with `en` = 1 → HIGH; `hcnt` = 1, `pcnt` = 1. Counts before the first rise are discarded.
  - HIGH: each cycle `hcnt`++, `pcnt`++. On `fall` → LOW with `pcnt`++ only.
  - LOW: each cycle `pcnt`++. On `rise`: push {`hcnt`, `pcnt`, sat_flag}, then `hcnt` = 1, `pcnt` = 1 → HIGH.
  - Example: 2 cycles high, 8 low → entry (2, 10).
- Counters saturate at 2^CNT_W−1 and never wrap. sat_flag is set if either counter hit the maximum during the period; it is cleared on the restart at `rise`.
- `en` falling: → IDLE next cycle; the partial measurement is discarded and the FIFO is untouched. Re-enable waits for a fresh `rise`.
- FIFO:
  - Show-ahead: `dout_*`/`sat` reflect the head whenever `rx_empty` = 0, and are don't-care when empty.
  - A push is visible one cycle after the `rise` cycle (`rx_empty` falls).
  - `pop` advances the head the next cycle.
  - Simultaneous push and pop when full: both succeed, count unchanged, no overrun.
  - Push when full with no pop: entry dropped, `overrun` set.
  - `overrun` clears only on reset.
- `pin_sel` change mid-measurement is legal but gives an undefined measurement. Software disables first.
- Reset mid-operation: everything returns to reset values immediately (async); the FIFO is emptied.

Optional Feature:
- PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: a 3-cycle filter sits after the synchronizer. `s` changes only after the raw synchronized value has held its new level for 3 consecutive cycles. Pulses of 1–2 cycles are ignored. Detection latency becomes SYNC_STAGES+3+1.
- Undefined: no filter; every synchronized transition counts.

Decomposition:
- Package `pwm_capture_pkg`: state enum (IDLE/HIGH/LOW), result entry struct {high, period, sat}, GLITCH_LEN = 3.
- One natural sub-module: `pwm_capture_fifo` (parameterised show-ahead FIFO with push/pop/full/empty). Also reusable for the PIO RX path.

Test Plan:
- Pin 0, waveform 4 high / 10 period, `en` = 1, 3 periods → 2 entries (4, 10), `sat` = 0. The first rise only starts a measurement.
- Drive `pio` with the PWM program (period 10, levels 2 then 4) and capture `gpio_out[0]` → period/high entries match the PIO divider-scaled cycle counts.
- No pops, 6 full periods → `rx_full` = 1 after 4 entries, `overrun` = 1, then 4 pops return the first 4 measurements in order.
- CNT_W = 8, period 300 (high 100) → entry (100, 255), `sat` = 1.
- `en` dropped mid-HIGH, then re-enabled → no partial entry; the next entry is a full period. Reset pulse (`reset` = 0) mid-LOW → `rx_empty` = 1 and `overrun` = 0 immediately.
- With PWM_CAPTURE_GLITCH_FILTER_EN: a 2-cycle low glitch inside a 6-cycle high → entry high = 6; without the macro, two short entries are recorded.
